// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// captured request payload and access-size helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } lsu_req_t;

  // Unknown funct3 codes fall back to a full-word access.
  function automatic lsu_size_e access_size(input logic we, input logic [2:0] funct3);
    lsu_size_e sz;
    sz = SZ_W;
    if (we) begin
      if (funct3 == F3_B) sz = SZ_B;
      else if (funct3 == F3_H) sz = SZ_H;
    end else begin
      if (funct3 == F3_B || funct3 == F3_BU) sz = SZ_B;
      else if (funct3 == F3_H || funct3 == F3_HU) sz = SZ_H;
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] offset);
    return (sz == SZ_H && offset[0]) || (sz == SZ_W && offset != 2'b00);
  endfunction

  // Natural alignment: halfwords drop bit 0, words drop both low bits.
  function automatic logic [1:0] eff_offset(input lsu_size_e sz, input logic [1:0] offset);
    logic [1:0] off;
    case (sz)
      SZ_B:    off = offset;
      SZ_H:    off = {offset[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/halfword extract with sign or zero
// extension, and read-modify-write lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: ;
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Replace only the addressed byte lanes of the old word.
  always_comb begin
    store_word = rdata;
    for (int i = 0; i < 4; i++) begin
      case (size)
        SZ_B: if (offset == 2'(i)) store_word[8*i +: 8] = wdata[7:0];
        SZ_H: if (offset[1] == i[1]) store_word[8*i +: 8] = i[0] ? wdata[15:8] : wdata[7:0];
        default: store_word[8*i +: 8] = wdata[8*i +: 8];
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RISC-V style load/store unit: IDLE/ACCESS/MERGE/RESP FSM with registered
// outputs. Define LSU_MISALIGN_TRAP_EN to report misaligned accesses via resp_err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [1:0]        off_q, off_d;
  logic              trap_q, trap_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  lsu_size_e         in_size, cur_size;
  logic              in_trap;
  logic [DATA_W-1:0] load_data, store_word;

  assign in_size  = access_size(req_we, req_funct3);
  assign cur_size = access_size(req_q.we, req_q.funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign in_trap = is_misaligned(in_size, req_addr[1:0]);
`else
  assign in_trap = 1'b0;
`endif

  lsu_align u_align (
    .size       (cur_size),
    .sign_ext   (~req_q.funct3[2]),
    .offset     (off_q),
    .rdata      (mem_rdata),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    off_d        = off_q;
    trap_d       = trap_q;
    req_ready_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    word_d       = word_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          state_d     = ACCESS;
          req_ready_d = 1'b0;
          req_d       = '{we: req_we, funct3: req_funct3, wdata: req_wdata};
          off_d       = eff_offset(in_size, req_addr[1:0]);
          trap_d      = in_trap;
          mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          if (!in_trap) begin
            if (!req_we || in_size != SZ_W) begin
              mem_read_d = 1'b1;
            end else begin
              mem_write_d = 1'b1;
              word_d      = req_wdata;
            end
          end
        end
      end
      ACCESS: begin
        if (trap_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
        end else if (!req_q.we) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
          resp_err_d   = 1'b0;
        end else if (cur_size != SZ_W) begin
          state_d     = MERGE;
          mem_write_d = 1'b1;
          word_d      = store_word;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      MERGE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      off_q        <= '0;
      trap_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      word_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      off_q        <= off_d;
      trap_q       <= trap_d;
      req_ready_q  <= req_ready_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      word_q       <= word_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = word_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// requests against a byte-level memory reference model.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid, resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];
  logic        pl_en;
  logic [6:0]  pl_idx;
  logic [31:0] pl_val;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          nwr;
    int          nrd;
    logic        clash;
    logic [8:0]  saddr;
  } obs_t;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[8:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[8:2]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 7'(idx); pl_val = v;
    ref_mem[idx] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Expected behaviour of one request, computed from byte-level rules.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [8:0] a,
                           input logic [31:0] wd, output obs_t e);
    int s, off, idx;
    logic [31:0] m, v;
    logic trap;
    if (we) s = (f3 == 3'b000) ? 1 : ((f3 == 3'b001) ? 2 : 4);
    else    s = (f3 == 3'b000 || f3 == 3'b100) ? 1 : ((f3 == 3'b001 || f3 == 3'b101) ? 2 : 4);
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (s == 2 && a[0]) || (s == 4 && a[1:0] != 2'b00);
`endif
    idx = int'(a[8:2]);
    off = (s == 1) ? int'(a[1:0]) : ((s == 2) ? (int'(a[1:0]) / 2) * 2 : 0);
    m   = (s == 1) ? 32'hFF : ((s == 2) ? 32'hFFFF : 32'hFFFF_FFFF);
    e.rd = '0; e.err = 1'b0; e.clash = 1'b0; e.saddr = {a[8:2], 2'b00};
    e.lat = 2; e.nwr = 0; e.nrd = 0;
    if (trap) begin
      e.err = 1'b1;
    end else if (!we) begin
      v = (ref_mem[idx] >> (8 * off)) & m;
      if (s < 4 && !f3[2] && v[8*s-1]) v = v | ~m;
      e.rd  = v;
      e.nrd = 1;
    end else begin
      ref_mem[idx] = (ref_mem[idx] & ~(m << (8 * off))) | ((wd << (8 * off)) & (m << (8 * off)));
      e.nwr = 1;
      e.nrd = (s < 4) ? 1 : 0;
      e.lat = (s < 4) ? 3 : 2;
    end
  endtask

  // Drive one request and observe strobes and the response (bounded wait).
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, output obs_t o);
    int n;
    o.rd = '0; o.err = 1'b0; o.lat = -1; o.nwr = 0; o.nrd = 0; o.clash = 1'b0; o.saddr = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 10 && o.lat < 0; c++) begin
      if (mem_read || mem_write) o.saddr = mem_addr;
      if (mem_write) o.nwr++;
      if (mem_read) o.nrd++;
      if (mem_read && mem_write) o.clash = 1'b1;
      if (resp_valid) begin
        o.lat = c; o.rd = resp_rdata; o.err = resp_err;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    tests++; if (mem_addr !== '0) begin fails++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    tests++; if (mem_wdata !== '0) begin fails++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    tests++; if (resp_rdata !== '0) begin fails++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word_store_load;
    obs_t o, e;
    model_req(1'b1, 3'b010, 9'h010, 32'hCAFEF00D, e);
    run_req(1'b1, 3'b010, 9'h010, 32'hCAFEF00D, o);
    tests++; if (o.lat !== 2) begin fails++; $display("FAIL sw_latency: got %0d want 2", o.lat); end
    tests++; if (o.nwr !== 1) begin fails++; $display("FAIL sw_write_cycles: got %0d want 1", o.nwr); end
    tests++; if (o.saddr !== 9'h010) begin fails++; $display("FAIL sw_addr: got %h want 010", o.saddr); end
    tests++; if (mem[4] !== 32'hCAFEF00D) begin fails++; $display("FAIL sw_mem: got %h want cafef00d", mem[4]); end
    tests++; if (o.rd !== 32'h0) begin fails++; $display("FAIL sw_rdata_zero: got %h want 0", o.rd); end
    model_req(1'b0, 3'b010, 9'h010, 32'h0, e);
    run_req(1'b0, 3'b010, 9'h010, 32'h0, o);
    tests++; if (o.rd !== 32'hCAFEF00D) begin fails++; $display("FAIL lw_rdata: got %h want cafef00d", o.rd); end
    tests++; if (o.lat !== 2) begin fails++; $display("FAIL lw_latency: got %0d want 2", o.lat); end
  endtask

  task automatic test_byte_ext;
    obs_t o;
    preload(8, 32'h000080FF);
    run_req(1'b0, 3'b000, 9'h021, 32'h0, o);
    tests++; if (o.rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_sext: got %h want ffffff80", o.rd); end
    run_req(1'b0, 3'b100, 9'h021, 32'h0, o);
    tests++; if (o.rd !== 32'h00000080) begin fails++; $display("FAIL lbu_zext: got %h want 00000080", o.rd); end
    run_req(1'b0, 3'b001, 9'h020, 32'h0, o);
    tests++; if (o.rd !== 32'hFFFF80FF) begin fails++; $display("FAIL lh_sext: got %h want ffff80ff", o.rd); end
  endtask

  task automatic test_subword_store;
    obs_t o, e;
    preload(12, 32'h11223344);
    model_req(1'b1, 3'b000, 9'h032, 32'h000000AA, e);
    run_req(1'b1, 3'b000, 9'h032, 32'h000000AA, o);
    tests++; if (mem[12] !== 32'h11AA3344) begin fails++; $display("FAIL sb_mem: got %h want 11aa3344", mem[12]); end
    tests++; if (o.lat !== 3) begin fails++; $display("FAIL sb_latency: got %0d want 3", o.lat); end
    model_req(1'b1, 3'b001, 9'h030, 32'h0000BEEF, e);
    run_req(1'b1, 3'b001, 9'h030, 32'h0000BEEF, o);
    tests++; if (mem[12] !== 32'h11AABEEF) begin fails++; $display("FAIL sh_mem: got %h want 11aabeef", mem[12]); end
    tests++; if (o.lat !== 3) begin fails++; $display("FAIL sh_latency: got %0d want 3", o.lat); end
    tests++; if (o.clash !== 1'b0) begin fails++; $display("FAIL sh_strobe_clash: got %b want 0", o.clash); end
  endtask

  task automatic test_misalign;
    obs_t o;
    run_req(1'b0, 3'b010, 9'h013, 32'h0, o);
`ifdef LSU_MISALIGN_TRAP_EN
    tests++; if (o.err !== 1'b1) begin fails++; $display("FAIL mis_err: got %b want 1", o.err); end
    tests++; if (o.nrd + o.nwr !== 0) begin fails++; $display("FAIL mis_strobes: got %0d want 0", o.nrd + o.nwr); end
    tests++; if (o.rd !== 32'h0) begin fails++; $display("FAIL mis_rdata: got %h want 0", o.rd); end
`else
    tests++; if (o.err !== 1'b0) begin fails++; $display("FAIL mis_err: got %b want 0", o.err); end
    tests++; if (o.saddr !== 9'h010) begin fails++; $display("FAIL mis_addr: got %h want 010", o.saddr); end
    tests++; if (o.rd !== 32'hCAFEF00D) begin fails++; $display("FAIL mis_rdata: got %h want cafef00d", o.rd); end
`endif
  endtask

  task automatic test_reset_merge;
    obs_t o;
    int stray;
    preload(16, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 9'h041; req_wdata = 32'h99;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    tests++; if (mem_read !== 1'b1) begin fails++; $display("FAIL rm_access_read: got %b want 1", mem_read); end
    @(negedge clk);
    tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL rm_merge_write: got %b want 1", mem_write); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rm_ready: got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rm_resp_valid: got %b want 0", resp_valid); end
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL rm_mem_write: got %b want 0", mem_write); end
    tests++; if (resp_rdata !== '0) begin fails++; $display("FAIL rm_rdata_clear: got %h want 0", resp_rdata); end
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    tests++; if (stray !== 0) begin fails++; $display("FAIL rm_stray_resp: got %0d want 0", stray); end
    preload(16, 32'h0BADF00D);
    run_req(1'b0, 3'b010, 9'h040, 32'h0, o);
    tests++; if (o.rd !== 32'h0BADF00D) begin fails++; $display("FAIL rm_next_rdata: got %h want 0badf00d", o.rd); end
    tests++; if (o.lat !== 2) begin fails++; $display("FAIL rm_next_latency: got %0d want 2", o.lat); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_rd [3];
    obs_t e;
    int accepts, resps, since, last, ready_bad, gap_bad, rd_bad;
    logic took;
    for (int i = 0; i < 3; i++) begin
      preload(20 + i, $urandom);
      model_req(1'b0, 3'b010, 9'(9'h050 + 4 * i), 32'h0, e);
      exp_rd[i] = e.rd;
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h050; req_wdata = '0;
    accepts = 0; resps = 0; since = 99; last = -1; ready_bad = 0; gap_bad = 0; rd_bad = 0; took = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (took) begin
        accepts++; since = 0;
        if (accepts == 3) req_valid = 1'b0;
        else req_addr = 9'(9'h050 + 4 * accepts);
      end else begin
        since++;
      end
      if (accepts > 0 && since < 2 && req_ready !== 1'b0) ready_bad++;
      if (accepts > 0 && accepts < 3 && since == 2 && req_ready !== 1'b1) ready_bad++;
      if (resp_valid) begin
        if (resps < 3 && resp_rdata !== exp_rd[resps]) rd_bad++;
        if (last >= 0 && cyc - last != 3) gap_bad++;
        last = cyc;
        resps++;
      end
      took = req_valid && req_ready;
      @(negedge clk);
    end
    tests++; if (resps !== 3) begin fails++; $display("FAIL b2b_resp_count: got %0d want 3", resps); end
    tests++; if (gap_bad !== 0) begin fails++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", gap_bad); end
    tests++; if (ready_bad !== 0) begin fails++; $display("FAIL b2b_ready: got %0d bad cycles want 0", ready_bad); end
    tests++; if (rd_bad !== 0) begin fails++; $display("FAIL b2b_rdata: got %0d bad words want 0", rd_bad); end
  endtask

  task automatic test_random;
    obs_t o, e;
    logic we;
    logic [2:0] f3;
    logic [8:0] a;
    logic [31:0] wd;
    int idx;
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 9'(9'h100 + $urandom_range(0, 63));
      wd = $urandom;
      idx = int'(a[8:2]);
      model_req(we, f3, a, wd, e);
      run_req(we, f3, a, wd, o);
      tests++; if (o.rd !== e.rd) begin fails++; $display("FAIL rnd_rdata we=%b f3=%0d a=%h: got %h want %h", we, f3, a, o.rd, e.rd); end
      tests++; if (o.err !== e.err) begin fails++; $display("FAIL rnd_err we=%b f3=%0d a=%h: got %b want %b", we, f3, a, o.err, e.err); end
      tests++; if (o.lat !== e.lat) begin fails++; $display("FAIL rnd_latency we=%b f3=%0d a=%h: got %0d want %0d", we, f3, a, o.lat, e.lat); end
      tests++; if (o.nwr !== e.nwr) begin fails++; $display("FAIL rnd_writes we=%b f3=%0d a=%h: got %0d want %0d", we, f3, a, o.nwr, e.nwr); end
      tests++; if (o.nrd !== e.nrd) begin fails++; $display("FAIL rnd_reads we=%b f3=%0d a=%h: got %0d want %0d", we, f3, a, o.nrd, e.nrd); end
      tests++; if (o.clash !== 1'b0) begin fails++; $display("FAIL rnd_strobe_clash a=%h: got %b want 0", a, o.clash); end
      tests++; if (mem[idx] !== ref_mem[idx]) begin fails++; $display("FAIL rnd_mem a=%h: got %h want %h", a, mem[idx], ref_mem[idx]); end
      if (e.nwr + e.nrd > 0) begin
        tests++; if (o.saddr !== e.saddr) begin fails++; $display("FAIL rnd_addr a=%h: got %h want %h", a, o.saddr, e.saddr); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    repeat (3) @(posedge clk);
    test_reset;
    for (int i = 0; i < 128; i++) preload(i, $urandom);
    test_word_store_load;
    test_byte_ext;
    test_subword_store;
    test_misalign;
    test_reset_merge;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL be the byte-address width of the data memory.
REQ-002 Parameter DATA_W, default 32, SHALL be the memory word width; only 32 is supported.
REQ-003 Clock: clk, input, 1 bit; single clock, rising-edge.
REQ-004 Reset: reset, input, 1 bit; synchronous, active-high.
REQ-005 req_valid, input, 1 bit: core presents a memory request.
REQ-006 req_ready, output, 1 bit: unit accepts a request this cycle.
REQ-007 req_we, input, 1 bit: 1 for store, 0 for load.
REQ-008 req_funct3, input, 3 bits: RISC-V size/sign code.
REQ-009 req_addr, input, ADDR_W bits: byte address.
REQ-010 req_wdata, input, DATA_W bits: store data, right-aligned.
REQ-011 resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 resp_rdata, output, DATA_W bits: load result, extended to 32 bits.
REQ-013 resp_err, output, 1 bit: misaligned request, valid with resp_valid.
REQ-014 mem_read and mem_write, outputs, 1 bit each: data-memory read and write strobes.
REQ-015 mem_addr, output, ADDR_W bits: word-aligned memory address.
REQ-016 mem_wdata, output, DATA_W bits; mem_rdata, input, DATA_W bits: combinational read data.

Function
REQ-017 The unit SHALL use the FSM states IDLE, ACCESS, MERGE and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 at a clock edge, and the unit SHALL capture all request fields at that edge.
REQ-019 IDLE SHALL go to ACCESS on accept.
REQ-020 ACCESS SHALL drive mem_addr = {addr[ADDR_W-1:2], 2'b00}.
REQ-021 In ACCESS, a load or a sub-word store SHALL assert mem_read; an SW SHALL assert mem_write with mem_wdata = wdata.
REQ-022 ACCESS SHALL go to RESP for loads and SW, and to MERGE for SB/SH, capturing mem_rdata in a word register.
REQ-023 MERGE SHALL assert mem_write with the captured word with only the addressed byte (SB) or halfword (SH) lanes replaced by the low bits of wdata, then go to RESP.
REQ-024 RESP SHALL assert resp_valid for exactly one cycle, then go to IDLE.
REQ-025 Latency from accept edge to resp_valid SHALL be 2 cycles for loads and SW, and 3 cycles for SB/SH.
REQ-026 Loads SHALL select lanes by addr[1:0]: LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend; LW is 010.
REQ-027 Any other load funct3 SHALL act as LW, and any other store funct3 as SW.
REQ-028 mem_read and mem_write SHALL never be asserted in the same cycle, and SHALL be 0 in IDLE and RESP.
REQ-029 resp_rdata SHALL hold its value until the next load completes, and SHALL be 0 for stores.

Reset
REQ-030 A reset edge SHALL force IDLE and clear the captured word, resp_rdata and resp_err.
REQ-031 From that edge, outputs SHALL be mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0, resp_valid = 0 and req_ready = 1.
REQ-032 On reset in ACCESS or MERGE, the in-flight request SHALL be dropped with no response; a write strobe may already have been issued in ACCESS or MERGE.
REQ-033 Reset SHALL take priority over an accept in the same cycle.

Configuration
REQ-034 With macro LSU_MISALIGN_TRAP_EN defined, LH/LHU/SH with addr[0] = 1, and LW/SW with addr[1:0] != 0, SHALL skip memory access: ACCESS goes straight to RESP, with no strobes, resp_err = 1 and resp_rdata = 0.
REQ-035 Without LSU_MISALIGN_TRAP_EN, misaligned halfword accesses SHALL force addr[0] to 0, word accesses SHALL force addr[1:0] to 0, and resp_err SHALL be tied to 0.

Structure
REQ-036 Package lsu_pkg SHALL hold the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state encoding.
REQ-037 Sub-module lsu_align (combinational) SHALL perform load lane extract and extend, and store lane merge; the FSM stays in load_store_unit.

Verification
REQ-038 Word store then load: SW at 0x010 with 0xCAFEF00D, then LW at 0x010 -> mem_write for one cycle at 0x010; resp_rdata = 0xCAFEF00D, 2 cycles after accept.
REQ-039 Byte load extension: word 0x000080FF at 0x020; LB at 0x021 -> 0xFFFFFF80; LBU at 0x021 -> 0x00000080; LH at 0x020 -> 0xFFFF80FF.
REQ-040 Sub-word stores: memory 0x11223344 at 0x030; SB at 0x032 with 0xAA -> 0x11AA3344; SH at 0x030 with 0xBEEF -> 0x11AABEEF; each response 3 cycles after accept.
REQ-041 Misalignment: LW at 0x013 -> with LSU_MISALIGN_TRAP_EN, resp_err = 1 and no strobes; without it, word at 0x010 is read and resp_err = 0.
REQ-042 Reset: assert reset in MERGE of an SB -> next cycle IDLE, req_ready = 1, no resp_valid, and the following request completes normally.
REQ-043 Back-to-back: req_valid held high for 3 LWs -> req_ready low in ACCESS and RESP, exactly 3 resp_valid pulses, 3 cycles apart.
